// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (rq/ack/wr_ni handshake) between N_CLIENTS
// requesters, with a per-transaction timeout that frees the bus from a silent memory.
module ram_arbiter #(
    parameter int unsigned N_CLIENTS  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_CLIENTS-1:0]             c_rq,
    input  logic [N_CLIENTS-1:0]             c_wr_ni,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  c_address,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0]  c_dataW,
    output logic [N_CLIENTS-1:0]             c_ack,
    output logic [DATA_WIDTH-1:0]            c_dataR,
    output logic [N_CLIENTS-1:0]             grant,
    output logic                             timeout_err,
    output logic                             m_rq,
    output logic                             m_wr_ni,
    output logic [ADDR_WIDTH-1:0]            m_address,
    output logic [DATA_WIDTH-1:0]            m_dataW,
    input  logic                             m_ack,
    input  logic [DATA_WIDTH-1:0]            m_dataR
);

    localparam int unsigned PTR_W   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e                 state_q, state_d;
    logic [N_CLIENTS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [PTR_W-1:0]       gidx;
    logic [PTR_W-1:0]       ptr_next;
    logic [PTR_W-1:0]       win;
    logic                   found;
    logic                   owner_rq;
    logic                   done;

    // Grant is only non-zero in BUSY, so the port mux needs no state decode.
    always_comb begin
        gidx      = '0;
        m_address = '0;
        m_dataW   = '0;
        m_wr_ni   = 1'b0;
        for (int i = 0; i < int'(N_CLIENTS); i++) begin
            if (grant_q[i]) begin
                gidx      = PTR_W'(i);
                m_address = c_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_dataW   = c_dataW[i*DATA_WIDTH +: DATA_WIDTH];
                m_wr_ni   = c_wr_ni[i];
            end
        end
    end

    assign owner_rq = |(grant_q & c_rq);
    assign done     = m_ack & owner_rq;
    assign m_rq     = owner_rq;
    assign c_ack    = grant_q & c_rq & {N_CLIENTS{m_ack}};
    assign c_dataR  = m_dataR;
    assign grant    = grant_q;
    assign timeout_err = timeout_err_q;
    assign ptr_next = (gidx == PTR_W'(N_CLIENTS - 1)) ? '0 : gidx + 1'b1;

    // First requester at or after the pointer, wrapping modulo N_CLIENTS.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < int'(N_CLIENTS); k++) begin
            idx  = (int'(ptr_q) + k) % int'(N_CLIENTS);
            cand = PTR_W'(idx);
            if (!found && c_rq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    cnt_d        = '0;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                // Completion and abort both take priority over the timeout.
                if (done || !owner_rq) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = StRelease;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    grant_d       = '0;
                    ptr_d         = ptr_next;
                    state_d       = StRelease;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: scoreboard of expected grant order plus a behavioural RAM
// that acks two cycles after m_rq rises (or never, when mem_dead is set).
module tb_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      c_rq;
    logic [N-1:0]      c_wr_ni;
    logic [N*AW-1:0]   c_address;
    logic [N*DW-1:0]   c_dataW;
    logic [N-1:0]      c_ack;
    logic [DW-1:0]     c_dataR;
    logic [N-1:0]      grant;
    logic              timeout_err;
    logic              m_rq;
    logic              m_wr_ni;
    logic [AW-1:0]     m_address;
    logic [DW-1:0]     m_dataW;
    logic              m_ack;
    logic [DW-1:0]     m_dataR;

    ram_arbiter #(
        .N_CLIENTS  (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .c_rq        (c_rq),
        .c_wr_ni     (c_wr_ni),
        .c_address   (c_address),
        .c_dataW     (c_dataW),
        .c_ack       (c_ack),
        .c_dataR     (c_dataR),
        .grant       (grant),
        .timeout_err (timeout_err),
        .m_rq        (m_rq),
        .m_wr_ni     (m_wr_ni),
        .m_address   (m_address),
        .m_dataW     (m_dataW),
        .m_ack       (m_ack),
        .m_dataR     (m_dataR)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    int            dly;
    bit            mem_dead;
    logic [N-1:0]  hold;
    logic          p_mrq, p_mack, p_mwr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_dw;
    logic [N-1:0]  p_cack;
    logic [N-1:0]  last_grant;
    logic [N-1:0]  sb [$];
    int            ack_cnt [N];
    int            terr_cnt, mrq_cnt;
    logic [DW-1:0] rdata_last;
    int            n_pass, n_fail, n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        terr_cnt   = 0;
        mrq_cnt    = 0;
        rdata_last = '0;
    endtask

    task automatic set_client(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic rd);
        c_address[i*AW +: AW] = a;
        c_dataW[i*DW +: DW]   = d;
        c_wr_ni[i]            = rd;
    endtask

    // One clock: RAM and clients react to what they saw before the edge, then the monitor runs.
    task automatic step();
        p_mrq  = m_rq;
        p_mack = m_ack;
        p_mwr  = m_wr_ni;
        p_addr = m_address;
        p_dw   = m_dataW;
        p_cack = c_ack;
        @(posedge clk);
        #1;
        if (p_mrq && p_mack && !p_mwr) mem[p_addr] = p_dw;
        if (!p_mrq || p_mack || mem_dead || reset) begin
            dly   = 0;
            m_ack = 1'b0;
        end else begin
            dly++;
            m_ack = (dly == 2);
        end
        c_rq = c_rq & ~(p_cack & ~hold);
        #1;
        m_dataR = mem[m_address];
        chk("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("inv_ack_within_grant", 32'(c_ack & ~grant), 32'd0);
        chk("inv_mrq_needs_grant", 32'(m_rq && grant == '0), 32'd0);
        if (p_cack != '0) chk("release_mrq_low", 32'(m_rq), 32'd0);
        for (int i = 0; i < N; i++) ack_cnt[i] += int'(c_ack[i]);
        if (c_ack != '0) rdata_last = c_dataR;
        terr_cnt += int'(timeout_err);
        mrq_cnt  += int'(m_rq);
        if (grant != '0 && grant != last_grant) begin
            if (sb.size() == 0) chk("sb_unexpected_grant", 32'(grant), 32'd0);
            else                chk("sb_grant_order", 32'(grant), 32'(sb.pop_front()));
        end
        last_grant = grant;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        c_rq     = '0;
        hold     = '0;
        mem_dead = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
        clear_stats();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (c_rq != '0 && k < 200) begin
            step();
            k++;
        end
        chk({tag, "_drain"}, 32'(c_rq), 32'd0);
        step();
        step();
        step();
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        n_pass = 0; n_fail = 0; n_total = 0;
        reset = 1'b1; c_rq = '0; c_wr_ni = '0; c_address = '0; c_dataW = '0;
        m_ack = 1'b0; m_dataR = '0; dly = 0; mem_dead = 1'b0; hold = '0;
        last_grant = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        clear_stats();

        // 1: write then read back through client 1
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mrq", 32'(m_rq), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_cack", 32'(c_ack), 32'd0);
        chk("rst_maddr", 32'({m_address, m_dataW, m_wr_ni}), 32'd0);
        set_client(1, 4'd5, 8'hA5, 1'b0);
        c_rq[1] = 1'b1;
        sb.push_back(4'b0010);
        step();
        chk("t1_wr_grant", 32'(grant), 32'h2);
        chk("t1_wr_mux", 32'({m_rq, m_wr_ni, m_address, m_dataW}), 32'({1'b1, 1'b0, 4'd5, 8'hA5}));
        drain("t1_wr");
        chk("t1_wr_ack1", 32'(ack_cnt[1]), 32'd1);
        chk("t1_wr_ack_other", 32'(ack_cnt[0] + ack_cnt[2] + ack_cnt[3]), 32'd0);
        clear_stats();
        set_client(1, 4'd5, 8'h00, 1'b1);
        c_rq[1] = 1'b1;
        sb.push_back(4'b0010);
        step();
        chk("t1_rd_grant", 32'(grant), 32'h2);
        drain("t1_rd");
        chk("t1_rd_ack1", 32'(ack_cnt[1]), 32'd1);
        chk("t1_rd_data", 32'(rdata_last), 32'hA5);
        chk("t1_rd_ack_other", 32'(ack_cnt[0] + ack_cnt[2] + ack_cnt[3]), 32'd0);

        // 2: all four request together
        do_reset();
        for (int i = 0; i < N; i++) set_client(i, 4'(i + 8), 8'(8'h10 + i), 1'b0);
        c_rq = 4'hF;
        sb.push_back(4'b0001); sb.push_back(4'b0010);
        sb.push_back(4'b0100); sb.push_back(4'b1000);
        drain("t2");
        for (int i = 0; i < N; i++) chk("t2_ack_each", 32'(ack_cnt[i]), 32'd1);

        // 3: clients 0 and 2 request continuously
        do_reset();
        set_client(0, 4'd1, 8'h11, 1'b0);
        set_client(2, 4'd2, 8'h22, 1'b0);
        hold = 4'b0101;
        c_rq = 4'b0101;
        for (int r = 0; r < 3; r++) begin
            sb.push_back(4'b0001);
            sb.push_back(4'b0100);
        end
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk("t3_sequence_done", 32'(sb.size()), 32'd0);
        c_rq[0] = 1'b0;
        hold    = '0;
        drain("t3");
        chk("t3_client2_served", 32'(ack_cnt[2]), 32'd3);

        // 4: memory never acks, client 3 times out, pending client 0 goes next
        do_reset();
        mem_dead = 1'b1;
        set_client(3, 4'd3, 8'h33, 1'b0);
        c_rq[3] = 1'b1;
        sb.push_back(4'b1000);
        sb.push_back(4'b0001);
        step();
        chk("t4_grant3", 32'(grant), 32'h8);
        set_client(0, 4'd0, 8'h44, 1'b0);
        c_rq[0] = 1'b1;
        k = 0;
        while (terr_cnt == 0 && k < 40) begin
            step();
            k++;
        end
        chk("t4_mrq_cycles", 32'(mrq_cnt), 32'(TO));
        chk("t4_terr_seen", 32'(terr_cnt), 32'd1);
        chk("t4_grant_released", 32'(grant), 32'd0);
        c_rq[3]  = 1'b0;
        mem_dead = 1'b0;
        drain("t4");
        chk("t4_terr_single", 32'(terr_cnt), 32'd1);
        chk("t4_no_ack3", 32'(ack_cnt[3]), 32'd0);
        chk("t4_ack0", 32'(ack_cnt[0]), 32'd1);

        // 5: client 2 aborts before ack
        do_reset();
        set_client(2, 4'd7, 8'h77, 1'b0);
        c_rq[2] = 1'b1;
        sb.push_back(4'b0100);
        step();
        chk("t5_grant2", 32'(grant), 32'h4);
        step();
        c_rq[2] = 1'b0;
        #1;
        chk("t5_mrq_same_cycle", 32'(m_rq), 32'd0);
        step();
        chk("t5_release_grant", 32'(grant), 32'd0);
        chk("t5_release_mrq", 32'(m_rq), 32'd0);
        drain("t5");
        chk("t5_no_ack2", 32'(ack_cnt[2]), 32'd0);

        // 6: reset during BUSY of client 1, pointer must return to 0
        do_reset();
        set_client(1, 4'd9, 8'h99, 1'b0);
        set_client(3, 4'd10, 8'hAA, 1'b0);
        hold    = 4'b0010;
        c_rq[1] = 1'b1;
        sb.push_back(4'b0010);
        step();
        chk("t6_grant1", 32'(grant), 32'h2);
        step();
        reset = 1'b1;
        step();
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_mrq", 32'(m_rq), 32'd0);
        chk("t6_rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        hold  = '0;
        c_rq  = 4'b1010;
        sb.push_back(4'b0010);
        sb.push_back(4'b1000);
        step();
        chk("t6_ptr_reset_winner", 32'(grant), 32'h2);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
